// File: rtl/mux3_rr_arbiter_if.sv
// Handshake bundle between three requesters and the
// round-robin arbiter that drives the shared 3:1 mux selects.
interface mux3_rr_arbiter_if;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [1:0] owner;

  modport master (
    output req,
    input  gnt, s1, s0, busy, owner
  );

  modport slave (
    input  req,
    output gnt, s1, s0, busy, owner
  );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for one shared 3:1 gate-level mux.
// Optional BURST_LIMIT_EN caps consecutive grant cycles at MAX_BURST.
module mux3_rr_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux3_rr_arbiter_if.slave bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15 ||
      (2 ** CNT_W) <= MAX_BURST) begin : g_bad_cfg
    $error("mux3_rr_arbiter: bad MAX_BURST/CNT_W");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             s1_q, s1_d;
  logic             s0_q, s0_d;
  logic             busy_q, busy_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       others;
  logic             hold;
  logic [1:0]       win;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First requester found scanning start, start+1, start+2 (mod 3).
  function automatic logic [1:0] pick(
    input logic [2:0] r,
    input logic [1:0] start
  );
    logic [1:0] i;
    logic       found;
    logic [1:0] w;
    i     = start;
    found = 1'b0;
    w     = start;
    for (int k = 0; k < 3; k++) begin
      if (!found && r[i]) begin
        w     = i;
        found = 1'b1;
      end
      i = nxt(i);
    end
    return w;
  endfunction

  // Next-state: arbitrate from idle, hold, or hand over at the same edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    others  = bus.req & ~gnt_q;
    hold    = bus.req[owner_q];
    win     = 2'd0;
`ifdef BURST_LIMIT_EN
    if (cnt_q >= CNT_W'(MAX_BURST) && |others) begin
      hold = 1'b0;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win          = pick(bus.req, nxt(last_q));
          gnt_d        = 3'b001 << win;
          {s1_d, s0_d} = win;
          owner_d      = win;
          busy_d       = 1'b1;
          cnt_d        = CNT_ONE;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (hold) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          last_d = owner_q;
          if (|others) begin
            win          = pick(others, nxt(owner_q));
            gnt_d        = 3'b001 << win;
            {s1_d, s0_d} = win;
            owner_d      = win;
            cnt_d        = CNT_ONE;
          end else begin
            gnt_d   = 3'b000;
            s1_d    = 1'b0;
            s0_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset points priority at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 2'd2;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = s1_q;
  assign bus.s0    = s0_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: directed scenarios
// plus randomized traffic against a rule-level reference model.
module tb_mux3_rr_arbiter;

  localparam int MB = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux3_rr_arbiter_if bus ();

  mux3_rr_arbiter #(
    .MAX_BURST(MB),
    .CNT_W    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {bus.gnt, bus.s1, bus.s0, bus.busy, bus.owner};

  int m_busy;
  int m_owner;
  int m_last;
  int m_cnt;

  function automatic int search(input int r, input int start);
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (start + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] rq);
    int q;
    int oth;
    bit rel;
    q = int'(rq);
    if (r) begin
      m_busy = 0; m_owner = 2; m_last = 2; m_cnt = 0;
    end else if (m_busy == 0) begin
      if (q != 0) begin
        m_owner = search(q, (m_last + 1) % 3);
        m_busy  = 1;
        m_cnt   = 1;
      end
    end else begin
      oth = q & ~(1 << m_owner);
      rel = (q[m_owner] == 1'b0);
`ifdef BURST_LIMIT_EN
      if (m_cnt >= MB && oth != 0) rel = 1;
`endif
      if (rel) begin
        m_last = m_owner;
        if (oth != 0) begin
          m_owner = search(oth, (m_owner + 1) % 3);
          m_cnt   = 1;
        end else begin
          m_busy = 0;
        end
      end else if (m_cnt < 15) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [2:0] g;
    logic [1:0] s;
    g = (m_busy != 0) ? 3'(1 << m_owner) : 3'b000;
    s = (m_busy != 0) ? 2'(m_owner) : 2'b00;
    return {g, s, (m_busy != 0), 2'(m_owner)};
  endfunction

  function automatic logic [7:0] grant_vec(input int o);
    return {3'(1 << o), 2'(o), 1'b1, 2'(o)};
  endfunction

  task automatic tick(input logic r, input logic [2:0] rq);
    rst     = r;
    bus.req = rq;
    @(posedge clk);
    model_step(r, rq);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 3'b000);
    tick(1'b1, 3'b000);
  endtask

  task automatic test_reset();
    tick(1'b1, 3'b111);
    tick(1'b1, 3'b111);
    checks++;
    if (obs !== 8'b000_00_0_10) begin
      errors++;
      $display("FAIL reset_vals got %b want %b", obs, 8'b000_00_0_10);
    end
    tick(1'b0, 3'b111);
    checks++;
    if (obs !== grant_vec(0)) begin
      errors++;
      $display("FAIL reset_first got %b want %b", obs, grant_vec(0));
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 3'b010);
      checks++;
      if (obs !== grant_vec(1)) begin
        errors++;
        $display("FAIL single_hold%0d got %b want %b",
                 i, obs, grant_vec(1));
      end
    end
    tick(1'b0, 3'b000);
    checks++;
    if (obs !== 8'b000_00_0_01) begin
      errors++;
      $display("FAIL single_drop got %b want %b", obs, 8'b000_00_0_01);
    end
  endtask

  task automatic test_rotation();
    int cur;
    int nx;
    do_reset();
    tick(1'b0, 3'b111);
    cur = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 3'b111);
      tick(1'b0, 3'b111);
      checks++;
      if (obs !== grant_vec(cur)) begin
        errors++;
        $display("FAIL rot_hold%0d got %b want %b",
                 k, obs, grant_vec(cur));
      end
      nx = (cur + 1) % 3;
      tick(1'b0, 3'(3'b111 & ~(3'b001 << cur)));
      checks++;
      if (obs !== grant_vec(nx)) begin
        errors++;
        $display("FAIL rot_next%0d got %b want %b",
                 k, obs, grant_vec(nx));
      end
      cur = nx;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b0, 3'b100);
    tick(1'b0, 3'b011);
    checks++;
    if (obs !== grant_vec(0)) begin
      errors++;
      $display("FAIL wrap_handover got %b want %b", obs, grant_vec(0));
    end
    do_reset();
    tick(1'b0, 3'b100);
    tick(1'b0, 3'b000);
    tick(1'b0, 3'b011);
    checks++;
    if (obs !== grant_vec(0)) begin
      errors++;
      $display("FAIL wrap_idle got %b want %b", obs, grant_vec(0));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b0, 3'b010);
    tick(1'b0, 3'b010);
    tick(1'b1, 3'b110);
    checks++;
    if (obs !== 8'b000_00_0_10) begin
      errors++;
      $display("FAIL rstmid_clear got %b want %b", obs, 8'b000_00_0_10);
    end
    tick(1'b0, 3'b110);
    checks++;
    if (obs !== grant_vec(1)) begin
      errors++;
      $display("FAIL rstmid_regrant got %b want %b", obs, grant_vec(1));
    end
  endtask

  task automatic test_burst();
    int o;
    do_reset();
    tick(1'b0, 3'b001);
    tick(1'b0, 3'b001);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 3'b101);
      o = 0;
`ifdef BURST_LIMIT_EN
      if (i + 3 > MB) o = 2;
`endif
      checks++;
      if (obs !== grant_vec(o)) begin
        errors++;
        $display("FAIL burst_cyc%0d got %b want %b",
                 i + 3, obs, grant_vec(o));
      end
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 3'b001);
      checks++;
      if (obs !== grant_vec(0)) begin
        errors++;
        $display("FAIL burst_sole%0d got %b want %b",
                 i, obs, grant_vec(0));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] rq;
    logic       r;
    logic [2:0] flip;
    do_reset();
    rq = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      flip = '0;
      for (int b = 0; b < 3; b++) begin
        flip[b] = ($urandom_range(0, 3) == 0);
      end
      rq = rq ^ flip;
      r  = ($urandom_range(0, 59) == 0);
      tick(r, rq);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cyc%0d req %b rst %b got %b want %b",
                 i, rq, r, obs, exp_vec());
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.req = 3'b000;
    m_busy  = 0;
    m_owner = 2;
    m_last  = 2;
    m_cnt   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_reset_mid();
    test_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
